// File: rtl/pio_read_arbiter.sv
// Round-robin arbiter sharing one registered-readdata PIO input slave among NUM_REQ readers.
// Optional change-detect interrupt on address 0 is enabled by defining PIO_ARB_CHANGE_IRQ_EN.
module pio_read_arbiter #(
   parameter int unsigned NUM_REQ      = 4,
   parameter int unsigned READ_LATENCY = 1
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [NUM_REQ-1:0]     req_read,
   input  logic [2*NUM_REQ-1:0]   req_address,
   output logic [NUM_REQ-1:0]     req_waitrequest,
   output logic [31:0]            req_readdata,
   output logic [NUM_REQ-1:0]     req_readdatavalid,
   output logic [1:0]             pio_address,
   input  logic [31:0]            pio_readdata
`ifdef PIO_ARB_CHANGE_IRQ_EN
   ,
   output logic                   irq,
   input  logic                   irq_ack
`endif
);

   localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int unsigned CntW = $clog2(READ_LATENCY + 1);

   typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

   state_e              state_q, state_d;
   logic [IdxW-1:0]     rr_q, rr_d;
   logic [IdxW-1:0]     gnt_q, gnt_d;
   logic [CntW-1:0]     cnt_q, cnt_d;
   logic [NUM_REQ-1:0]  wr_q, wr_d;
   logic [NUM_REQ-1:0]  rdv_q, rdv_d;
   logic [31:0]         rdata_q, rdata_d;
   logic [1:0]          pa_q, pa_d;

   logic                found;
   logic [IdxW-1:0]     winner;
   int unsigned         idx;

   // First requester at or after rr_q+1, wrapping.
   always_comb begin
      found  = 1'b0;
      winner = '0;
      idx    = 0;
      for (int unsigned k = 1; k <= NUM_REQ; k++) begin
         idx = (int'(rr_q) + k) % NUM_REQ;
         if (!found && req_read[idx]) begin
            found  = 1'b1;
            winner = IdxW'(idx);
         end
      end
   end

   always_comb begin
      state_d = state_q;
      rr_d    = rr_q;
      gnt_d   = gnt_q;
      cnt_d   = cnt_q;
      wr_d    = '1;
      rdv_d   = '0;
      rdata_d = rdata_q;
      pa_d    = pa_q;
      unique case (state_q)
         StIdle: begin
            if (found) begin
               gnt_d         = winner;
               rr_d          = winner;
               pa_d          = req_address[{winner, 1'b0} +: 2];
               wr_d[winner]  = 1'b0;
               state_d       = StIssue;
            end
         end
         StIssue: begin
            cnt_d   = CntW'(READ_LATENCY - 1);
            state_d = StWait;
         end
         StWait: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - CntW'(1);
            end else begin
               rdata_d       = pio_readdata;
               rdv_d[gnt_q]  = 1'b1;
               state_d       = StResp;
            end
         end
         StResp: begin
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StIdle;
         rr_q    <= IdxW'(NUM_REQ - 1);
         gnt_q   <= '0;
         cnt_q   <= '0;
         wr_q    <= '1;
         rdv_q   <= '0;
         rdata_q <= '0;
         pa_q    <= '0;
      end else begin
         state_q <= state_d;
         rr_q    <= rr_d;
         gnt_q   <= gnt_d;
         cnt_q   <= cnt_d;
         wr_q    <= wr_d;
         rdv_q   <= rdv_d;
         rdata_q <= rdata_d;
         pa_q    <= pa_d;
      end
   end

   assign req_waitrequest   = wr_q;
   assign req_readdatavalid = rdv_q;
   assign req_readdata      = rdata_q;
   assign pio_address       = pa_q;

`ifdef PIO_ARB_CHANGE_IRQ_EN
   logic        irq_q, irq_d;
   logic        have0_q, have0_d;
   logic [31:0] last0_q, last0_d;
   logic        irq_set;

   // Evaluated while the response is on the bus; pio_address still holds the read address.
   always_comb begin
      irq_set = 1'b0;
      have0_d = have0_q;
      last0_d = last0_q;
      if (state_q == StResp && pa_q == 2'd0) begin
         irq_set = have0_q && (rdata_q != last0_q);
         last0_d = rdata_q;
         have0_d = 1'b1;
      end
      irq_d = irq_q;
      if (irq_set) begin
         irq_d = 1'b1;
      end else if (irq_ack) begin
         irq_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         irq_q   <= 1'b0;
         have0_q <= 1'b0;
         last0_q <= '0;
      end else begin
         irq_q   <= irq_d;
         have0_q <= have0_d;
         last0_q <= last0_d;
      end
   end

   assign irq = irq_q;
`endif

endmodule

// File: tb/tb_pio_read_arbiter.sv
// Self-checking bench for pio_read_arbiter: directed scenarios plus randomized traffic
// compared every cycle against a transaction-level schedule model.
module tb_pio_read_arbiter;

   localparam int unsigned N  = 4;
   localparam int unsigned RL = 3;

   logic          clk = 1'b0;
   logic          reset;
   logic [N-1:0]  req_read;
   logic [2*N-1:0] req_address;
   logic [N-1:0]  req_waitrequest;
   logic [31:0]   req_readdata;
   logic [N-1:0]  req_readdatavalid;
   logic [1:0]    pio_address;
   logic [31:0]   pio_readdata;
`ifdef PIO_ARB_CHANGE_IRQ_EN
   logic          irq;
   logic          irq_ack;
`endif

   pio_read_arbiter #(
      .NUM_REQ      (N),
      .READ_LATENCY (RL)
   ) dut (
      .clk               (clk),
      .reset             (reset),
      .req_read          (req_read),
      .req_address       (req_address),
      .req_waitrequest   (req_waitrequest),
      .req_readdata      (req_readdata),
      .req_readdatavalid (req_readdatavalid),
      .pio_address       (pio_address),
      .pio_readdata      (pio_readdata)
`ifdef PIO_ARB_CHANGE_IRQ_EN
      ,
      .irq               (irq),
      .irq_ack           (irq_ack)
`endif
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   // Model: a read sampled in idle cycle t0 is accepted in t0+1, captures the data present
   // in t0+1+RL, responds in t0+2+RL, and the arbiter is free again at t0+3+RL.
   bit          m_on = 1'b0;
   logic [N-1:0] e_wr, e_rdv;
   logic [31:0] e_rd;
   logic [1:0]  e_pa;
   int          rr, tx_g, tx_t0, next_idle;
   bit          tx_act;
   logic [1:0]  tx_addr;
`ifdef PIO_ARB_CHANGE_IRQ_EN
   bit          m_irq, m_have0;
   logic [31:0] m_last0;
`endif

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
      end
   endtask

   task automatic model_step();
      logic [N-1:0] nwr, nrdv;
      bit irq_n;
      irq_n = 1'b0;
      if (reset) begin
         e_wr = '1; e_rdv = '0; e_rd = '0; e_pa = '0;
         rr = N - 1; tx_act = 1'b0; next_idle = cyc + 1; m_on = 1'b1;
`ifdef PIO_ARB_CHANGE_IRQ_EN
         m_irq = 1'b0; m_have0 = 1'b0; m_last0 = '0;
`endif
         return;
      end
      if (!m_on) return;
      nwr = '1;
      nrdv = '0;
`ifdef PIO_ARB_CHANGE_IRQ_EN
      irq_n = m_irq;
      if (irq_ack) irq_n = 1'b0;
`endif
      if (tx_act) begin
         if (cyc == tx_t0 + 1 + RL) e_rd = pio_readdata;
         if (cyc + 1 == tx_t0 + 2 + RL) nrdv[tx_g] = 1'b1;
         if (cyc == tx_t0 + 2 + RL) begin
`ifdef PIO_ARB_CHANGE_IRQ_EN
            if (tx_addr == 2'd0) begin
               if (m_have0 && e_rd != m_last0) irq_n = 1'b1;
               m_last0 = e_rd;
               m_have0 = 1'b1;
            end
`endif
            tx_act = 1'b0;
         end
      end
      if (!tx_act && cyc >= next_idle && req_read != '0) begin
         for (int k = 1; k <= N; k++) begin
            int j;
            j = (rr + k) % N;
            if (!tx_act && req_read[j]) begin
               tx_act = 1'b1; tx_g = j; tx_t0 = cyc; rr = j;
               tx_addr = req_address[2*j +: 2];
            end
         end
         nwr[tx_g] = 1'b0;
         e_pa = tx_addr;
         next_idle = cyc + 3 + RL;
      end
      e_wr = nwr;
      e_rdv = nrdv;
`ifdef PIO_ARB_CHANGE_IRQ_EN
      m_irq = irq_n;
`endif
   endtask

   // The one compare point: every cycle, outputs sampled 1 time unit after the edge.
   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
      cyc++;
      if (m_on) begin
         chk("waitrequest", req_waitrequest, e_wr);
         chk("readdatavalid", req_readdatavalid, e_rdv);
         chk("readdata", req_readdata, e_rd);
         chk("pio_address", pio_address, e_pa);
`ifdef PIO_ARB_CHANGE_IRQ_EN
         chk("irq", irq, m_irq);
`endif
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      req_read = '0;
      tick();
      tick();
      reset = 1'b0;
   endtask

   task automatic drain();
      req_read = '0;
      repeat (RL + 4) tick();
   endtask

   // Single read by requester i; returns in the response cycle, optionally acking irq there.
   task automatic do_read(input int i, input logic [1:0] a, input logic [31:0] d,
                          input bit ack_at_resp);
      bit done;
      done = 1'b0;
      req_read = '0;
      req_read[i] = 1'b1;
      req_address[2*i +: 2] = a;
      pio_readdata = d;
      for (int t = 0; t < 30 && !done; t++) begin
         tick();
         if (req_waitrequest[i] === 1'b0) req_read[i] = 1'b0;
         if (req_readdatavalid[i] === 1'b1) done = 1'b1;
      end
      if (!done) begin
         errors++;
         $display("FAIL read_timeout requester %0d: got no response expected one", i);
      end
`ifdef PIO_ARB_CHANGE_IRQ_EN
      if (ack_at_resp) begin
         irq_ack = 1'b1;
         tick();
         irq_ack = 1'b0;
      end
`else
      if (ack_at_resp) tick();
`endif
   endtask

   initial begin
      int g;
      bit seen;
      reset = 1'b1;
      req_read = '0;
      req_address = '0;
      pio_readdata = '0;
`ifdef PIO_ARB_CHANGE_IRQ_EN
      irq_ack = 1'b0;
`endif
      do_reset();
      tick();
      chk("reset_wr", req_waitrequest, 4'hF);
      chk("reset_rdv", req_readdatavalid, 4'h0);
      chk("reset_rdata", req_readdata, 32'h0);
      chk("reset_paddr", pio_address, 2'd0);

      // Single read from requester 0.
      req_read = 4'b0001;
      req_address = '0;
      pio_readdata = 32'h5A;
      tick();
      req_read = '0;
      chk("single_accept", req_waitrequest, 4'b1110);
      repeat (RL + 1) tick();
      chk("single_rdv", req_readdatavalid, 4'b0001);
      chk("single_data", req_readdata, 32'h5A);
      drain();

      // All requesting continuously from reset.
      do_reset();
      req_read = 4'hF;
      for (int i = 0; i < 8; i++) begin
         seen = 1'b0;
         g = -1;
         for (int t = 0; t < 20 && !seen; t++) begin
            tick();
            for (int j = 0; j < N; j++)
               if (req_waitrequest[j] === 1'b0) begin g = j; seen = 1'b1; end
         end
         chk("rr_order", g, i % N);
      end
      drain();

      // Reset during WAIT discards the read and restores rr_ptr.
      do_reset();
      req_read = 4'b0001;
      req_address = 8'b0000_0001;
      tick();
      req_read = '0;
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      for (int t = 0; t < RL + 3; t++) begin
         tick();
         chk("no_rdv_after_reset", req_readdatavalid, 4'h0);
      end
      req_read = 4'b1100;
      tick();
      chk("grant2_after_reset", req_waitrequest, 4'b1011);
      drain();

      // Requester 1 drops req_read during ISSUE; the read still completes.
      req_read = 4'b0010;
      req_address = 8'b0000_1000;
      pio_readdata = 32'h77;
      tick();
      chk("drop_accept", req_waitrequest, 4'b1101);
      req_read = '0;
      repeat (RL + 1) tick();
      chk("drop_rdv", req_readdatavalid, 4'b0010);
      drain();

      // Captured value is the one present RL cycles after the ISSUE cycle.
      req_read = 4'b0001;
      req_address = 8'b0000_0011;
      pio_readdata = 32'h100;
      tick();
      req_read = '0;
      for (int k = 1; k <= RL + 1; k++) begin
         pio_readdata = 32'h111 * k;
         tick();
      end
      chk("latency_rdv", req_readdatavalid, 4'b0001);
      chk("latency_data", req_readdata, 32'h444);
      chk("latency_paddr", pio_address, 2'd3);
      drain();

`ifdef PIO_ARB_CHANGE_IRQ_EN
      do_reset();
      do_read(0, 2'd0, 32'h10, 1'b0);
      tick();
      chk("irq_first", irq, 1'b0);
      do_read(0, 2'd0, 32'h10, 1'b0);
      tick();
      chk("irq_same", irq, 1'b0);
      do_read(0, 2'd0, 32'h11, 1'b0);
      tick();
      chk("irq_change", irq, 1'b1);
      irq_ack = 1'b1;
      tick();
      irq_ack = 1'b0;
      chk("irq_ack", irq, 1'b0);
      do_read(0, 2'd0, 32'h12, 1'b1);
      chk("irq_set_wins", irq, 1'b1);
      drain();
`else
      do_read(2, 2'd1, 32'hCAFE, 1'b0);
      chk("helper_data", req_readdata, 32'hCAFE);
      drain();
`endif

      // Randomized traffic, including occasional mid-operation resets.
      for (int t = 0; t < 3000; t++) begin
         reset = ($urandom_range(0, 299) == 0);
         req_read = N'($urandom) & N'($urandom);
         if ($urandom_range(0, 9) == 0) req_read = '1;
         req_address = (2*N)'($urandom);
         pio_readdata = $urandom;
`ifdef PIO_ARB_CHANGE_IRQ_EN
         irq_ack = ($urandom_range(0, 3) == 0);
         if ($urandom_range(0, 1) == 0) req_address = '0;
         if ($urandom_range(0, 1) == 0) pio_readdata = 32'($urandom_range(0, 1));
`endif
         tick();
      end
      reset = 1'b0;
`ifdef PIO_ARB_CHANGE_IRQ_EN
      irq_ack = 1'b0;
`endif
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
